stroke_rasterizer: RTL and testbench
====================================

STROKE_RASTERIZER -- requirements
Module: stroke_rasterizer

Interface
REQ-001 Parameter X_W, default 10, x-coordinate width.
REQ-002 Parameter Y_W, default 9, y-coordinate width.
REQ-003 Parameter SCREEN_W, default 640, visible columns; SCREEN_H, default 480, visible rows.
REQ-004 Parameter DATA_W, default 1, pixel word width.
REQ-005 Parameter FIFO_DEPTH, default 4, event queue entries (power of 2, >=2).
REQ-006 Parameter COLOR_L, default all-ones, left-button pixel value; COLOR_R, default 0, right-button pixel value.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 MOUSE_X_POS  in  X_W  pointer x; MOUSE_Y_POS  in  Y_W  pointer y.
REQ-010 MOUSE_LEFT, MOUSE_RIGHT  in  1 each  button levels, sampled with new_event.
REQ-011 new_event  in  1  one-cycle strobe: sample pointer and buttons.
REQ-012 brush2  in  1  0 = 1x1 brush, 1 = 2x2 brush; sampled at segment start.
REQ-013 wr_addr  out  Y_W+X_W  {y, x} framebuffer address.
REQ-014 wr_data  out  DATA_W  pixel value; wr_valid  out  1; wr_ready  in  1.
REQ-015 busy  out  1  queue non-empty or segment in progress; overflow  out  1  one-cycle pulse on dropped event.

Function
REQ-016 Every new_event SHALL push {x, y, left, right} into the FIFO unless it is full; when full, the event is dropped, overflow pulses for that cycle, and the FIFO is unchanged.
REQ-017 A push and pop in the same cycle with the FIFO full SHALL both succeed (no drop).
REQ-018 On pop, x SHALL clamp to SCREEN_W-1 and y to SCREEN_H-1 before use.
REQ-019 FSM states SHALL be IDLE, LOAD, DRAW, STEP; IDLE->LOAD when FIFO non-empty; LOAD pops one entry and selects the action.
REQ-020 Entry with neither button: pen_down<=0, last<=point, no writes, LOAD->IDLE.
REQ-021 Entry with a button and pen_down=0: plot the point only, pen_down<=1, last<=point.
REQ-022 Entry with a button, pen_down=1, point==last: no writes, LOAD->IDLE.
REQ-023 Otherwise: Bresenham line from last (excluded) to point (included), pen_down stays 1, last<=point at segment end.
REQ-024 Color SHALL be COLOR_L if left set, else COLOR_R (left priority); color and brush2 latched in LOAD for the whole segment.
REQ-025 Delta arithmetic SHALL be signed X_W+2 / Y_W+2 bits; decision term signed max(X_W,Y_W)+3 bits; major axis = |dx| > |dy| (ties: y major); minor step when D>0.
REQ-026 DRAW SHALL emit each brush pixel of the current point in order (0,0),(1,0),(0,1),(1,1); offsets with x>=SCREEN_W or y>=SCREEN_H are skipped without a write cycle.
REQ-027 wr_valid, wr_addr, wr_data SHALL be held stable until the cycle wr_ready=1; one pixel transfers per handshake cycle; back-to-back transfers allowed.
REQ-028 STEP advances one Bresenham step in one cycle then returns to DRAW; after the endpoint's pixels, FSM -> IDLE.
REQ-029 A 1x1 segment of N pixels with wr_ready held high SHALL complete in at most 2N+2 cycles from pop.
REQ-030 busy SHALL be 1 whenever FIFO non-empty or FSM not IDLE.

Reset
REQ-031 rst low SHALL asynchronously force: FSM IDLE, FIFO empty, pen_down 0, last (0,0), wr_valid 0, wr_addr 0, wr_data 0, busy 0, overflow 0.
REQ-032 Reset mid-segment SHALL abort it; no write completes after reset asserts; events during reset are ignored.
REQ-033 After rst deasserts, the first button event SHALL be treated as pen-down start (point only).

Verification
REQ-034 Left press at (10,5), then left at (14,5), wr_ready=1 -> writes {5,10},{5,11},{5,12},{5,13},{5,14}, data COLOR_L, no duplicate of (10,5).
REQ-035 Pen down (0,0), right event (3,7) -> 7 writes, y 1..7, x sequence 0,1,1,2,2,3,3 per Bresenham ties rule, data COLOR_R.
REQ-036 brush2=1, left at (639,479) -> exactly one write {479,639}; other three offsets skipped.
REQ-037 Five new_event strobes in consecutive cycles with wr_ready=0, FIFO_DEPTH=4 -> fifth dropped, overflow pulses once, four entries later processed in order.
REQ-038 wr_ready toggling 1,0,0,1 during a segment -> addr/data stable while wr_valid and ready low; no pixel lost or repeated.
REQ-039 rst low during DRAW of (0,0)->(100,0) -> wr_valid 0 immediately, busy 0; next left event at (50,50) writes only {50,50}.

Source files
------------

// File: rtl/stroke_rasterizer.sv
// Mouse-stroke rasterizer: queues pointer events and draws Bresenham line
// segments between successive pen-down points into a framebuffer write port.
module stroke_rasterizer #(
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int DATA_W = 1,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] COLOR_L = '1,
  parameter logic [DATA_W-1:0] COLOR_R = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [X_W-1:0]     MOUSE_X_POS,
  input  logic [Y_W-1:0]     MOUSE_Y_POS,
  input  logic               MOUSE_LEFT,
  input  logic               MOUSE_RIGHT,
  input  logic               new_event,
  input  logic               brush2,
  output logic [Y_W+X_W-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic               busy,
  output logic               overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = X_W + Y_W + 2;
  localparam int DW = ((X_W > Y_W) ? X_W : Y_W) + 3;
  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAW = 2'd2, STEP = 2'd3;

  logic [1:0]           state_reg;
  logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic                 fifo_full, fifo_pop, fifo_push;
  logic [X_W-1:0]       cur_x_reg, tgt_x_reg, last_x_reg;
  logic [Y_W-1:0]       cur_y_reg, tgt_y_reg, last_y_reg;
  logic                 pen_down_reg, brush2_reg, sx_neg_reg, sy_neg_reg, x_major_reg;
  logic [DATA_W-1:0]    color_reg;
  logic signed [DW-1:0] d_reg, inc_min_reg, inc_both_reg;
  logic [3:0]           done_reg;

  assign fifo_full = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign fifo_pop  = (state_reg == LOAD);
  assign fifo_push = new_event && (!fifo_full || fifo_pop);
  assign overflow  = new_event && fifo_full && !fifo_pop;
  assign busy      = (count_reg != '0) || (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (fifo_push)
      fifo_mem[wr_ptr_reg] <= {MOUSE_X_POS, MOUSE_Y_POS, MOUSE_LEFT, MOUSE_RIGHT};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  // Head entry, clamped onto the visible screen
  logic [X_W-1:0] head_x, pt_x;
  logic [Y_W-1:0] head_y, pt_y;
  logic           head_l, head_r;
  assign {head_x, head_y, head_l, head_r} = fifo_mem[rd_ptr_reg];
  assign pt_x = (head_x > X_MAX) ? X_MAX : head_x;
  assign pt_y = (head_y > Y_MAX) ? Y_MAX : head_y;

  logic signed [X_W+1:0] dx, adx;
  logic signed [Y_W+1:0] dy, ady;
  logic signed [DW-1:0]  adx_e, ady_e, dmaj, dmin;
  logic                  x_major;
  assign dx      = $signed({2'b00, pt_x}) - $signed({2'b00, last_x_reg});
  assign dy      = $signed({2'b00, pt_y}) - $signed({2'b00, last_y_reg});
  assign adx     = dx[X_W+1] ? -dx : dx;
  assign ady     = dy[Y_W+1] ? -dy : dy;
  assign adx_e   = DW'(adx);
  assign ady_e   = DW'(ady);
  assign x_major = adx_e > ady_e;
  assign dmaj    = x_major ? adx_e : ady_e;
  assign dmin    = x_major ? ady_e : adx_e;

  // Brush pixels in (0,0),(1,0),(0,1),(1,1) order; off-screen ones never enter the mask
  logic [3:0] px_mask, px_pend, px_sel;
  logic       x_room, y_room, off_x, off_y, px_last, at_end;
  assign x_room = (cur_x_reg != X_MAX);
  assign y_room = (cur_y_reg != Y_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_brush
      localparam bit OX = (gi % 2) == 1;
      localparam bit OY = gi >= 2;
      if (gi == 0) begin : g_origin
        assign px_mask[gi] = 1'b1;
      end else begin : g_offset
        assign px_mask[gi] = brush2_reg && (!OX || x_room) && (!OY || y_room);
      end
    end
  endgenerate

  assign px_pend  = px_mask & ~done_reg;
  assign px_sel   = px_pend & (~px_pend + 4'd1);
  assign off_x    = px_sel[1] | px_sel[3];
  assign off_y    = px_sel[2] | px_sel[3];
  assign px_last  = ((px_pend & ~px_sel) == 4'd0);
  assign at_end   = (cur_x_reg == tgt_x_reg) && (cur_y_reg == tgt_y_reg);
  assign wr_valid = (state_reg == DRAW) && (px_pend != 4'd0);
  assign wr_addr  = {cur_y_reg + Y_W'(off_y), cur_x_reg + X_W'(off_x)};
  assign wr_data  = color_reg;

  logic [X_W-1:0] step_x;
  logic [Y_W-1:0] step_y;
  logic           d_pos;
  assign step_x = sx_neg_reg ? cur_x_reg - 1'b1 : cur_x_reg + 1'b1;
  assign step_y = sy_neg_reg ? cur_y_reg - 1'b1 : cur_y_reg + 1'b1;
  assign d_pos  = !d_reg[DW-1] && (d_reg != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cur_x_reg    <= '0;
      cur_y_reg    <= '0;
      tgt_x_reg    <= '0;
      tgt_y_reg    <= '0;
      last_x_reg   <= '0;
      last_y_reg   <= '0;
      pen_down_reg <= 1'b0;
      brush2_reg   <= 1'b0;
      sx_neg_reg   <= 1'b0;
      sy_neg_reg   <= 1'b0;
      x_major_reg  <= 1'b0;
      color_reg    <= '0;
      d_reg        <= '0;
      inc_min_reg  <= '0;
      inc_both_reg <= '0;
      done_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (count_reg != '0) state_reg <= LOAD;
        LOAD: begin
          color_reg  <= head_l ? COLOR_L : COLOR_R;
          brush2_reg <= brush2;
          done_reg   <= '0;
          if (!head_l && !head_r) begin
            pen_down_reg <= 1'b0;
            last_x_reg   <= pt_x;
            last_y_reg   <= pt_y;
            state_reg    <= IDLE;
          end else if (!pen_down_reg) begin
            pen_down_reg <= 1'b1;
            last_x_reg   <= pt_x;
            last_y_reg   <= pt_y;
            cur_x_reg    <= pt_x;
            cur_y_reg    <= pt_y;
            tgt_x_reg    <= pt_x;
            tgt_y_reg    <= pt_y;
            state_reg    <= DRAW;
          end else if (pt_x == last_x_reg && pt_y == last_y_reg) begin
            state_reg <= IDLE;
          end else begin
            // Segment starts at last; the first STEP moves off it so it is not redrawn
            cur_x_reg    <= last_x_reg;
            cur_y_reg    <= last_y_reg;
            tgt_x_reg    <= pt_x;
            tgt_y_reg    <= pt_y;
            sx_neg_reg   <= dx[X_W+1];
            sy_neg_reg   <= dy[Y_W+1];
            x_major_reg  <= x_major;
            d_reg        <= (dmin <<< 1) - dmaj;
            inc_min_reg  <= dmin <<< 1;
            inc_both_reg <= (dmin - dmaj) <<< 1;
            state_reg    <= STEP;
          end
        end
        DRAW: if (wr_valid && wr_ready) begin
          done_reg <= done_reg | px_sel;
          if (px_last) begin
            if (at_end) begin
              last_x_reg <= cur_x_reg;
              last_y_reg <= cur_y_reg;
              state_reg  <= IDLE;
            end else begin
              state_reg <= STEP;
            end
          end
        end
        default: begin
          if (x_major_reg) cur_x_reg <= step_x;
          else             cur_y_reg <= step_y;
          if (d_pos) begin
            if (x_major_reg) cur_y_reg <= step_y;
            else             cur_x_reg <= step_x;
            d_reg <= d_reg + inc_both_reg;
          end else begin
            d_reg <= d_reg + inc_min_reg;
          end
          done_reg  <= '0;
          state_reg <= DRAW;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stroke_rasterizer.sv
// Directed bench for stroke_rasterizer: expected framebuffer writes are queued
// as events are sent and matched in order against each completed handshake.
module tb_stroke_rasterizer;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int DATA_W = 1;
  localparam logic [DATA_W-1:0] CL = '1;
  localparam logic [DATA_W-1:0] CR = '0;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [X_W-1:0]     mx = '0;
  logic [Y_W-1:0]     my = '0;
  logic               ml = 1'b0, mr = 1'b0, new_event = 1'b0, brush2 = 1'b0;
  logic [Y_W+X_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_valid, wr_ready = 1'b1, busy, overflow;

  stroke_rasterizer #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(640), .SCREEN_H(480), .DATA_W(DATA_W),
    .FIFO_DEPTH(4), .COLOR_L(CL), .COLOR_R(CR)
  ) dut (
    .clk(clk), .rst(rst), .MOUSE_X_POS(mx), .MOUSE_Y_POS(my),
    .MOUSE_LEFT(ml), .MOUSE_RIGHT(mr), .new_event(new_event), .brush2(brush2),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef logic [Y_W+X_W+DATA_W-1:0] wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ov_count = 0;
  logic hold_pending = 1'b0;
  wr_t  held;

  function automatic wr_t mk(input int x, input int y, input logic [DATA_W-1:0] c);
    return {Y_W'(y), X_W'(x), c};
  endfunction

  // Scoreboard monitor: one line per completed write, stall stability check
  always @(negedge clk) begin
    if (!rst) begin
      hold_pending = 1'b0;
    end else begin
      if (overflow) ov_count++;
      if (hold_pending) begin
        checks++;
        assert (wr_valid === 1'b1 && {wr_addr, wr_data} === held) else begin
          errors++;
          $error("FAIL hold_stable: got valid=%0b word=%h, required valid=1 word=%h", wr_valid, {wr_addr, wr_data}, held);
        end
      end
      if (wr_valid && wr_ready) begin
        $display("write y=%0d x=%0d data=%h", wr_addr[Y_W+X_W-1:X_W], wr_addr[X_W-1:0], wr_data);
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_write: got word=%h, required no write", {wr_addr, wr_data});
        end
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          checks++;
          assert ({wr_addr, wr_data} === e) else begin
            errors++;
            $error("FAIL write_word: got %h, required %h", {wr_addr, wr_data}, e);
          end
        end
      end
      hold_pending = wr_valid && !wr_ready;
      held = {wr_addr, wr_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_event(input int x, input int y, input logic l, input logic r,
                            input logic exp_ov, input string tag);
    mx = X_W'(x); my = Y_W'(y); ml = l; mr = r; new_event = 1'b1;
    @(negedge clk);
    checks++;
    assert (overflow === exp_ov) else begin
      errors++;
      $error("FAIL %s overflow: got %0b, required %0b", tag, overflow, exp_ov);
    end
    tick();
    new_event = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    assert (n < max_cyc) else begin
      errors++;
      $error("FAIL %s idle_timeout: got busy=%0b pending=%0d, required busy=0 pending=0", tag, busy, exp_q.size());
    end
  endtask

  task automatic pen_up();
    send_event(0, 0, 1'b0, 1'b0, 1'b0, "pen_up");
    wait_idle(20, "pen_up");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ov_base;
    logic [3:0] pat;

    // Reset state
    repeat (3) tick();
    checks++; assert (wr_valid === 1'b0) else begin errors++; $error("FAIL rst_valid: got %0b, required 0", wr_valid); end
    checks++; assert (wr_addr === '0) else begin errors++; $error("FAIL rst_addr: got %h, required 0", wr_addr); end
    checks++; assert (wr_data === '0) else begin errors++; $error("FAIL rst_data: got %h, required 0", wr_data); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL rst_busy: got %0b, required 0", busy); end
    checks++; assert (overflow === 1'b0) else begin errors++; $error("FAIL rst_overflow: got %0b, required 0", overflow); end
    rst = 1'b1;
    tick();

    // Horizontal stroke, start point not repeated
    exp_q.push_back(mk(10, 5, CL));
    send_event(10, 5, 1'b1, 1'b0, 1'b0, "h_start");
    for (int i = 11; i <= 14; i++) exp_q.push_back(mk(i, 5, CL));
    send_event(14, 5, 1'b1, 1'b0, 1'b0, "h_end");
    wait_idle(60, "horizontal");

    // Negative-x, x-major segment from (14,5) to (10,8)
    exp_q.push_back(mk(13, 6, CL));
    exp_q.push_back(mk(12, 6, CL));
    exp_q.push_back(mk(11, 7, CL));
    exp_q.push_back(mk(10, 8, CL));
    send_event(10, 8, 1'b1, 1'b0, 1'b0, "neg_seg");
    wait_idle(60, "neg_seg");

    // Right button, y-major tie rule, cycle budget
    pen_up();
    exp_q.push_back(mk(0, 0, CR));
    send_event(0, 0, 1'b0, 1'b1, 1'b0, "r_start");
    wait_idle(20, "r_start");
    exp_q.push_back(mk(0, 1, CR));
    exp_q.push_back(mk(1, 2, CR));
    exp_q.push_back(mk(1, 3, CR));
    exp_q.push_back(mk(2, 4, CR));
    exp_q.push_back(mk(2, 5, CR));
    exp_q.push_back(mk(3, 6, CR));
    exp_q.push_back(mk(3, 7, CR));
    send_event(3, 7, 1'b0, 1'b1, 1'b0, "r_seg");
    n = 0;
    do begin tick(); n++; end while (busy && n < 40);
    checks++;
    assert (n <= 2 * 7 + 3) else begin errors++; $error("FAIL seg_cycles: got %0d, required <= %0d", n, 2 * 7 + 3); end
    send_event(3, 7, 1'b0, 1'b1, 1'b0, "same_point");
    wait_idle(20, "same_point");

    // Clamp to the screen edge
    pen_up();
    exp_q.push_back(mk(639, 479, CL));
    send_event(1000, 500, 1'b1, 1'b0, 1'b0, "clamp");
    wait_idle(20, "clamp");

    // 2x2 brush at the corner and in the interior
    brush2 = 1'b1;
    pen_up();
    exp_q.push_back(mk(639, 479, CL));
    send_event(639, 479, 1'b1, 1'b0, 1'b0, "corner");
    wait_idle(20, "corner");
    pen_up();
    exp_q.push_back(mk(20, 30, CL));
    exp_q.push_back(mk(21, 30, CL));
    exp_q.push_back(mk(20, 31, CL));
    exp_q.push_back(mk(21, 31, CL));
    send_event(20, 30, 1'b1, 1'b0, 1'b0, "brush_mid");
    wait_idle(20, "brush_mid");
    brush2 = 1'b0;

    // Queue overflow while the writer is stalled
    pen_up();
    wr_ready = 1'b0;
    exp_q.push_back(mk(100, 100, CL));
    send_event(100, 100, 1'b1, 1'b0, 1'b0, "stall_start");
    repeat (3) tick();
    ov_base = ov_count;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(100 + i, 100, CL));
      send_event(100 + i, 100, 1'b1, 1'b0, 1'b0, "fill");
    end
    send_event(105, 100, 1'b1, 1'b0, 1'b1, "drop");
    checks++;
    assert (ov_count - ov_base === 1) else begin errors++; $error("FAIL overflow_pulses: got %0d, required 1", ov_count - ov_base); end
    wr_ready = 1'b1;
    wait_idle(60, "overflow_drain");

    // Ready toggling 1,0,0,1 during a segment
    pen_up();
    pat = 4'b1001;
    exp_q.push_back(mk(200, 10, CL));
    send_event(200, 10, 1'b1, 1'b0, 1'b0, "tog_start");
    for (int i = 201; i <= 204; i++) exp_q.push_back(mk(i, 10, CL));
    send_event(204, 10, 1'b1, 1'b0, 1'b0, "tog_end");
    for (int i = 0; i < 24; i++) begin
      wr_ready = pat[i % 4];
      tick();
    end
    wr_ready = 1'b1;
    wait_idle(60, "toggle");

    // Reset in the middle of a long segment
    pen_up();
    exp_q.push_back(mk(0, 0, CL));
    send_event(0, 0, 1'b1, 1'b0, 1'b0, "long_start");
    for (int i = 1; i <= 100; i++) exp_q.push_back(mk(i, 0, CL));
    send_event(100, 0, 1'b1, 1'b0, 1'b0, "long_end");
    repeat (20) tick();
    #3 rst = 1'b0;
    #1;
    checks++; assert (wr_valid === 1'b0) else begin errors++; $error("FAIL abort_valid: got %0b, required 0", wr_valid); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL abort_busy: got %0b, required 0", busy); end
    checks++; assert (wr_addr === '0) else begin errors++; $error("FAIL abort_addr: got %h, required 0", wr_addr); end
    exp_q.delete();
    send_event(7, 7, 1'b1, 1'b0, 1'b0, "in_reset");
    tick();
    rst = 1'b1;
    tick();
    exp_q.push_back(mk(50, 50, CL));
    send_event(50, 50, 1'b1, 1'b0, 1'b0, "after_reset");
    wait_idle(20, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
